// File: rtl/weight_mem_arbiter.sv
// Burst arbiter sharing the single-port weight RAM between LD(0), FP(1) and BP(2).
// Round-robin by default; define WARB_FIXED_PRIO_EN for fixed priority BP > FP > LD.
module weight_mem_arbiter #(
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 16,
    parameter int MEM_LAT = 2
) (
    input  logic                  clk,
    input  logic                  rst_l,
    input  logic [2:0]            req,
    input  logic [2:0]            we,
    input  logic [3*ADDR_W-1:0]   base_addr,
    input  logic [3*8-1:0]        burst_len,
    input  logic [3*DATA_W-1:0]   wdata,
    output logic [2:0]            gnt,
    output logic [2:0]            ack,
    output logic [2:0]            rvalid,
    output logic [DATA_W-1:0]     rdata,
    output logic                  busy,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata
);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_BURST = 2'd1, S_DRAIN = 2'd2} state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [1:0]        r_owner;
    logic [2:0]        r_gnt;
    logic              r_we;
    logic [ADDR_W-1:0] r_base;
    logic [7:0]        r_len;
    logic [7:0]        r_beat;
    logic [2:0]        r_drain;
    logic [2:0]        r_pipe [MEM_LAT];

    logic [ADDR_W-1:0] w_base_arr  [3];
    logic [7:0]        w_len_arr   [3];
    logic [DATA_W-1:0] w_wdata_arr [3];
    logic              w_pick_vld;
    logic [1:0]        w_pick;
    logic              w_last_beat;
    logic              w_drain_done;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_slice
            assign w_base_arr[gi]  = base_addr[gi*ADDR_W +: ADDR_W];
            assign w_len_arr[gi]   = burst_len[gi*8 +: 8];
            assign w_wdata_arr[gi] = wdata[gi*DATA_W +: DATA_W];
        end
    endgenerate

`ifdef WARB_FIXED_PRIO_EN
    always_comb begin
        w_pick_vld = |req;
        w_pick     = 2'd0;
        if (req[2])
            w_pick = 2'd2;
        else if (req[1])
            w_pick = 2'd1;
    end
`else
    logic [1:0] r_last_owner;
    logic [1:0] w_order [3];

    // Search order starts just above the last owner, so it ends up lowest priority.
    always_comb begin
        case (r_last_owner)
            2'd0:    w_order = '{2'd1, 2'd2, 2'd0};
            2'd1:    w_order = '{2'd2, 2'd0, 2'd1};
            default: w_order = '{2'd0, 2'd1, 2'd2};
        endcase
        w_pick_vld = |req;
        w_pick     = w_order[0];
        for (int k = 2; k >= 0; k--) begin
            if (req[w_order[k]])
                w_pick = w_order[k];
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l)
            r_last_owner <= 2'd2;
        else if (r_state == S_IDLE && w_pick_vld)
            r_last_owner <= w_pick;
    end
`endif

    assign w_last_beat  = (r_beat == r_len);
    assign w_drain_done = (r_drain == 3'(MEM_LAT - 1));

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l)
            r_state <= S_IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        gnt          = r_gnt;
        busy         = (r_state != S_IDLE);
        ack          = 3'b000;
        mem_en       = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        case (r_state)
            S_IDLE: begin
                if (w_pick_vld)
                    w_state_next = S_BURST;
            end
            S_BURST: begin
                mem_en    = 1'b1;
                mem_we    = r_we;
                mem_addr  = r_base + ADDR_W'(r_beat);
                mem_wdata = w_wdata_arr[r_owner];
                ack       = r_gnt;
                if (w_last_beat)
                    w_state_next = r_we ? S_IDLE : S_DRAIN;
            end
            S_DRAIN: begin
                if (w_drain_done)
                    w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_owner <= 2'd0;
            r_gnt   <= 3'b000;
            r_we    <= 1'b0;
            r_base  <= '0;
            r_len   <= 8'd0;
            r_beat  <= 8'd0;
            r_drain <= 3'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pick_vld) begin
                        r_owner <= w_pick;
                        r_gnt   <= 3'b001 << w_pick;
                        r_we    <= we[w_pick];
                        r_base  <= w_base_arr[w_pick];
                        r_len   <= w_len_arr[w_pick];
                        r_beat  <= 8'd0;
                    end
                end
                S_BURST: begin
                    r_beat  <= r_beat + 8'd1;
                    r_drain <= 3'd0;
                    if (w_last_beat && r_we)
                        r_gnt <= 3'b000;
                end
                S_DRAIN: begin
                    r_drain <= r_drain + 3'd1;
                    if (w_drain_done)
                        r_gnt <= 3'b000;
                end
                default: r_gnt <= 3'b000;
            endcase
        end
    end

    // Owner tag of each outstanding read travels alongside the RAM latency.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            for (int k = 0; k < MEM_LAT; k++)
                r_pipe[k] <= 3'b000;
        end else begin
            r_pipe[0] <= (r_state == S_BURST && !r_we) ? r_gnt : 3'b000;
            for (int k = 1; k < MEM_LAT; k++)
                r_pipe[k] <= r_pipe[k-1];
        end
    end

    assign rvalid = r_pipe[MEM_LAT-1];
    assign rdata  = (|r_pipe[MEM_LAT-1]) ? mem_rdata : '0;

endmodule
